// File: rtl/gpio_uart_tx_if.sv
// gpio_uart_tx_if -- GPIO store port from the core's memory stage.
//
// Signals:
//   GPIOEn    store strobe; one write per cycle while high
//   GPIOaddr  32-bit store address
//   GPIO      store data byte
//
// Modports:
//   master  core side, drives the store
//   slave   peripheral side, samples the store
interface gpio_uart_tx_if;
  logic        GPIOEn;
  logic [31:0] GPIOaddr;
  logic [7:0]  GPIO;

  modport master (output GPIOEn, output GPIOaddr, output GPIO);
  modport slave  (input  GPIOEn, input  GPIOaddr, input  GPIO);
endinterface

// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx -- memory-mapped UART transmitter on the GPIO store port.
//
// Byte stores to DATA_ADDR are queued in a DEPTH-entry FIFO and sent as
// UART frames, LSB first. A store to CLR_ADDR clears the sticky overflow
// flag. The core is never stalled: a store that finds the FIFO full (and
// no pop in the same cycle) is dropped and sets overflow.
//
// Optional feature macro: UART_TX_PARITY_EN
//   undefined -> 8N1 frame, 10*CLKS_PER_BIT cycles
//   defined   -> 8E1 frame (even parity bit after bit 7), 11*CLKS_PER_BIT cycles
//
// Ports:
//   clk       rising-edge clock (same as the core)
//   rst       asynchronous active-low reset
//   bus       GPIO store port (slave modport)
//   tx        serial line, idle high, registered
//   busy      frame in progress
//   empty     FIFO empty
//   full      FIFO holds DEPTH entries
//   count     FIFO occupancy, $clog2(DEPTH)+1 bits
//   overflow  sticky: a data store was dropped
module gpio_uart_tx #(
  parameter int          DEPTH        = 8,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] DATA_ADDR    = 32'h0000_1000,
  parameter logic [31:0] CLR_ADDR     = 32'h0000_1001
) (
  input  logic                   clk,
  input  logic                   rst,
  gpio_uart_tx_if.slave          bus,
  output logic                   tx,
  output logic                   busy,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // FIFO storage: no reset so it maps onto block/distributed RAM.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;

  state_t        state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          busy_reg;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg;
`endif

  logic data_hit;
  logic clr_hit;
  logic pop;
  logic push;
  logic baud_last;

  assign data_hit  = bus.GPIOEn && (bus.GPIOaddr == DATA_ADDR);
  assign clr_hit   = bus.GPIOEn && (bus.GPIOaddr == CLR_ADDR);
  // Pop depends only on registered state, so a push into a full FIFO can
  // be accepted in the same cycle the head entry leaves.
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign push      = data_hit && (!full || pop);
  assign baud_last = (baud_reg == BAUD_LAST);

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_C);
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign tx       = tx_reg;
  assign busy     = busy_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.GPIO;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (clr_hit) begin
        overflow_reg <= 1'b0;
      end else if (data_hit && full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Transmit FSM. tx is set one cycle ahead of each bit period, so the
  // value loaded at a bit boundary is what the line shows for the whole
  // following period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          baud_reg <= '0;
          if (pop) begin
            shift_reg  <= mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^mem[rd_ptr_reg];
`endif
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_reg    <= '0;
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_reg  <= '0;
            tx_reg    <= 1'b1;
            state_reg <= STOP;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_reg  <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          baud_reg  <= '0;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// tb_gpio_uart_tx -- self-checking bench for gpio_uart_tx.
//
// Bytes accepted by the peripheral are queued as expected frames when the
// store is driven; a line receiver decodes tx and compares each received
// byte against the head of that queue. Directed timing checks cover frame
// latency, busy duration, FIFO fill/overflow, ignored stores and a reset
// in the middle of a frame. Honours UART_TX_PARITY_EN.
module tb_gpio_uart_tx;

  localparam int          CPB    = 4;
  localparam int          DEP    = 4;
  localparam logic [31:0] DATA_A = 32'h0000_1000;
  localparam logic [31:0] CLR_A  = 32'h0000_1001;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  // Receiver tick (negedges since start detected) of the stop-bit midpoint.
  localparam int STOP_TICK = FRAME - 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx;
  logic       busy;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  gpio_uart_tx_if bus ();

  gpio_uart_tx #(
    .DEPTH        (DEP),
    .CLKS_PER_BIT (CPB),
    .DATA_ADDR    (DATA_A),
    .CLR_ADDR     (CLR_A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx       (tx),
    .busy     (busy),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         rx_starts[$];
  int         cyc = 0;
  logic       rx_busy = 1'b0;
  int         rx_tick = 0;
  logic [7:0] rx_shift = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) cyc <= cyc + 1;

  // Line receiver: samples tx at the middle of each bit period.
  always @(negedge clk) begin
    if (!rst) begin
      rx_busy <= 1'b0;
      rx_tick <= 0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy <= 1'b1;
        rx_tick <= 1;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_tick <= rx_tick + 1;
      if (rx_tick == 2) begin
        check("rx_start_bit", 32'(tx), 32'(1'b0));
      end else if (rx_tick >= 6 && rx_tick <= 34 && ((rx_tick - 6) % 4) == 0) begin
        rx_shift <= {tx, rx_shift[7:1]};
`ifdef UART_TX_PARITY_EN
      end else if (rx_tick == 38) begin
        check("rx_parity", 32'(tx), 32'(^rx_shift));
`endif
      end else if (rx_tick == STOP_TICK) begin
        check("rx_stop_bit", 32'(tx), 32'(1'b1));
        if (exp_q.size() == 0) begin
          check("rx_unexpected_frame", 32'(rx_shift), 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", 32'(rx_shift), 32'(exp_q.pop_front()));
        end
        rx_busy <= 1'b0;
      end
    end
  end

  task automatic put(input logic [31:0] addr, input logic [7:0] data, input logic en);
    @(negedge clk);
    bus.GPIOEn   = en;
    bus.GPIOaddr = addr;
    bus.GPIO     = data;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.GPIOEn   = 1'b0;
    bus.GPIOaddr = 32'h0;
    bus.GPIO     = 8'h00;
  endtask

  task automatic wait_drain(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && empty) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_in_time", 32'(done), 32'(1'b1));
  endtask

  // Single store at edge N: tx low from N+1, busy falls at N+1+FRAME.
  task automatic timed_frame(input logic [7:0] b);
    put(DATA_A, b, 1'b1);
    exp_q.push_back(b);
    bus_idle();
    check("count_after_push", 32'(count), 32'd1);
    check("tx_before_start", 32'(tx), 32'(1'b1));
    @(negedge clk);
    check("tx_start_low", 32'(tx), 32'(1'b0));
    check("busy_at_start", 32'(busy), 32'(1'b1));
    check("count_after_pop", 32'(count), 32'd0);
    repeat (FRAME - 1) @(negedge clk);
    check("busy_last_stop", 32'(busy), 32'(1'b1));
    check("tx_stop_high", 32'(tx), 32'(1'b1));
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'(1'b0));
    check("frame_received", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.GPIOEn   = 1'b0;
    bus.GPIOaddr = 32'h0;
    bus.GPIO     = 8'h00;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_tx", 32'(tx), 32'(1'b1));
    check("reset_busy", 32'(busy), 32'(1'b0));
    check("reset_empty", 32'(empty), 32'(1'b1));
    check("reset_full", 32'(full), 32'(1'b0));
    check("reset_count", 32'(count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'(1'b0));

    timed_frame(8'h55);
`ifdef UART_TX_PARITY_EN
    timed_frame(8'h07);
    timed_frame(8'h03);
`endif

    // Burst: 0x01 pops at once, 0x02..0x05 fill, 0x06 is dropped.
    base = rx_starts.size();
    for (int k = 1; k <= 6; k++) begin
      put(DATA_A, 8'(k), 1'b1);
      if (k <= 5) exp_q.push_back(8'(k));
    end
    bus_idle();
    check("burst_count", 32'(count), 32'd4);
    check("burst_full", 32'(full), 32'(1'b1));
    check("burst_overflow", 32'(overflow), 32'(1'b1));
    wait_drain(600);
    check("burst_frames", 32'(rx_starts.size() - base), 32'd5);
    for (int k = base + 1; k < rx_starts.size(); k++) begin
      check("frame_gap", 32'(rx_starts[k] - rx_starts[k-1]), 32'(FRAME + 1));
    end
    check("overflow_sticky", 32'(overflow), 32'(1'b1));
    put(CLR_A, 8'hFF, 1'b1);
    bus_idle();
    check("overflow_cleared", 32'(overflow), 32'(1'b0));
    check("clr_no_push", 32'(count), 32'd0);

    // Ignored stores: wrong address, and strobe low at the data address.
    put(32'h0000_2000, 8'h99, 1'b1);
    put(DATA_A, 8'h98, 1'b0);
    bus_idle();
    repeat (4) @(negedge clk);
    check("ignored_count", 32'(count), 32'd0);
    check("ignored_tx", 32'(tx), 32'(1'b1));
    check("ignored_busy", 32'(busy), 32'(1'b0));

    // Reset during data bit 3 of 0x11 with 0x22, 0x33 queued.
    put(DATA_A, 8'h11, 1'b1);
    put(DATA_A, 8'h22, 1'b1);
    put(DATA_A, 8'h33, 1'b1);
    bus_idle();
    repeat (16) @(negedge clk);
    check("pre_rst_count", 32'(count), 32'd2);
    check("pre_rst_tx_bit3", 32'(tx), 32'(1'b0));
    check("pre_rst_busy", 32'(busy), 32'(1'b1));
    #1 rst = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'(1'b1));
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_empty", 32'(empty), 32'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    put(DATA_A, 8'hA3, 1'b1);
    exp_q.push_back(8'hA3);
    bus_idle();
    wait_drain(200);

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_uart_tx.md
Name: gpio_uart_tx

Overview:
- Memory-mapped serial transmit peripheral on the processor's GPIO store port (GPIOaddr/GPIO/GPIOEn from the memory stage).
- Byte stores to a data address are buffered in a FIFO and shifted out as 8N1 UART frames, LSB first.
- Core never stalls: full FIFO drops the byte and sets a sticky overflow flag.
- Status outputs are for LEDs/debug; no read-back path into the core.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >=2.
- CLKS_PER_BIT, 434, clk cycles per serial bit; >=2.
- DATA_ADDR, 32'h0000_1000, store address that pushes a byte.
- CLR_ADDR, 32'h0000_1001, store address that clears overflow; data ignored.

Ports:
- clk  in  1  rising-edge clock, same as core.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- GPIOEn  in  1  store strobe; one write per cycle it is high.
- GPIOaddr  in  32  store address.
- GPIO  in  8  store data byte.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress (FSM not IDLE).
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a DATA_ADDR store was dropped.

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, empty=1, full=0, count=0, overflow=0; FIFO pointers 0; FSM=IDLE; baud counter 0. Reset mid-frame aborts the frame with tx high immediately, no glitch low.
- Address decode is exact 32-bit compare; stores to any other address are ignored.
- Push: GPIOEn && GPIOaddr==DATA_ADDR && (!full || pop this cycle). The byte is written at the rising edge.
- Full push, no pop: byte is dropped, overflow<=1, count unchanged.
- Full push with pop in the same cycle: push accepted, count stays DEPTH.
- Overflow clear: GPIOEn && GPIOaddr==CLR_ADDR sets overflow<=0. Clearing wins over a simultaneous overflow set; this cannot coincide anyway, since addresses differ.
- Pop: occurs only in IDLE when !empty (registered). Head byte is loaded into the shift register; read pointer advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- full = (count==DEPTH); empty = (count==0); both are registered-state derived.
- FSM states and tx values:
  - IDLE: tx=1. If !empty, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; bit index 0..7; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on each bit boundary. tx is a registered output.
- Latency: store sampled at edge N -> FIFO non-empty after N -> pop at edge N+1 -> tx=0 from edge N+1 onward.
- Frame is 10*CLKS_PER_BIT cycles. Back-to-back frames: next START begins 1 cycle after STOP ends (one IDLE cycle, tx=1).
- busy=1 in START/DATA/STOP (and PARITY when enabled).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an extra PARITY state between DATA and STOP, tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1 frame of 10*CLKS_PER_BIT cycles. All other behaviour identical.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
- Reset then idle 20 cycles -> tx=1, busy=0, empty=1, count=0, overflow=0.
- Single store 0x55 to DATA_ADDR at edge N:
  - tx low from edge N+1 for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each.
  - Then stop high 4 cycles.
  - busy falls at N+41.
- 6 consecutive stores 0x01..0x06 while the first frame starts:
  - 0x01 popped immediately, 0x02..0x05 fill the FIFO (count=4, full=1).
  - 0x06 dropped, overflow=1.
  - Serial output carries 0x01..0x05 in order, 41 cycles apart.
  - After a CLR_ADDR store, overflow=0.
- Store to 32'h0000_2000 and a store with GPIOEn=0 at DATA_ADDR -> count stays 0, tx stays 1.
- Assert rst=0 during DATA bit 3 with 2 bytes queued -> tx=1, count=0, busy=0 immediately.
  - After release, a new store 0xA3 transmits correctly.
- With UART_TX_PARITY_EN, store 0x07 -> parity bit=1 after bit 7, frame 44 cycles.
  - Store 0x03 -> parity bit=0.
